// File: rtl/shift_engine_seq_if.sv
// Request/result bundle of the sequential shifter. The requester uses the master modport.
// The shifter uses the slave modport.
interface shift_engine_seq_if #(
    parameter int WIDTH = 128,
    parameter int AMT_W = 8
);
    logic             start;
    logic [2:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] din;
    logic             serial_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] dout;
    logic             carry_out;

    modport master (
        output start, mode, amount, din, serial_in,
        input  busy, done, dout, carry_out
    );

    modport slave (
        input  start, mode, amount, din, serial_in,
        output busy, done, dout, carry_out
    );
endinterface

// File: rtl/shift_engine_seq.sv
// Multi-mode sequential shifter that performs one bit of shift or rotate per clock.
// A one-cycle done pulse marks the result. dout holds the result until the next accepted start.
module shift_engine_seq #(
    parameter int WIDTH = 128,
    parameter int AMT_W = 8
) (
    input  logic                clock,
    input  logic                reset,
    shift_engine_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] M_LSL  = 3'd0;
    localparam logic [2:0] M_LSR  = 3'd1;
    localparam logic [2:0] M_ASR  = 3'd2;
    localparam logic [2:0] M_ROL  = 3'd3;
    localparam logic [2:0] M_ROR  = 3'd4;
    localparam logic [2:0] M_SHLS = 3'd5;
    localparam logic [2:0] M_SHRS = 3'd6;

    localparam logic [AMT_W-1:0] WIDTH_CNT = AMT_W'(WIDTH);
    localparam logic [AMT_W-1:0] ONE_CNT   = AMT_W'(1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             carry_reg, carry_next;
    logic [AMT_W-1:0] cnt_reg, cnt_next;
    logic [2:0]       mode_reg, mode_next;

    logic [AMT_W-1:0] n_eff;
    logic [WIDTH-1:0] step_dout;
    logic             step_carry;

    // Neighbour views of the working register. Only the fill bit differs between modes.
    logic [WIDTH-1:1] up_body;
    logic [WIDTH-2:0] down_body;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_neigh
            assign up_body[gi+1] = dout_reg[gi];
            assign down_body[gi] = dout_reg[gi+1];
        end
    endgenerate

    // Rotates keep the raw amount, so a full turn simply costs extra cycles.
    always_comb begin
        n_eff = bus.amount;
        case (bus.mode)
            M_ROL, M_ROR: n_eff = bus.amount;
            3'd7:         n_eff = '0;
            default:      n_eff = (bus.amount > WIDTH_CNT) ? WIDTH_CNT : bus.amount;
        endcase
    end

    always_comb begin
        {step_carry, step_dout} = {carry_reg, dout_reg};
        case (mode_reg)
            M_LSL:  {step_carry, step_dout} = {dout_reg[WIDTH-1], up_body, 1'b0};
            M_LSR:  {step_carry, step_dout} = {dout_reg[0], 1'b0, down_body};
            M_ASR:  {step_carry, step_dout} = {dout_reg[0], dout_reg[WIDTH-1], down_body};
            M_ROL:  {step_carry, step_dout} = {dout_reg[WIDTH-1], up_body, dout_reg[WIDTH-1]};
            M_ROR:  {step_carry, step_dout} = {dout_reg[0], dout_reg[0], down_body};
            M_SHLS: {step_carry, step_dout} = {dout_reg[WIDTH-1], up_body, bus.serial_in};
            M_SHRS: {step_carry, step_dout} = {dout_reg[0], bus.serial_in, down_body};
            default: {step_carry, step_dout} = {carry_reg, dout_reg};
        endcase
    end

    always_comb begin
        state_next = state_reg;
        dout_next  = dout_reg;
        carry_next = carry_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    dout_next  = bus.din;
                    carry_next = 1'b0;
                    cnt_next   = n_eff;
                    mode_next  = bus.mode;
                    state_next = (n_eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                dout_next  = step_dout;
                carry_next = step_carry;
                cnt_next   = cnt_reg - ONE_CNT;
                if (cnt_reg == ONE_CNT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            dout_reg  <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            mode_reg  <= '0;
        end else begin
            state_reg <= state_next;
            dout_reg  <= dout_next;
            carry_reg <= carry_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
        end
    end

    assign bus.busy      = (state_reg != IDLE);
    assign bus.done      = (state_reg == DONE);
    assign bus.dout      = dout_reg;
    assign bus.carry_out = carry_reg;
endmodule

// File: tb/tb_shift_engine_seq.sv
// Scoreboard bench for shift_engine_seq with one instance at WIDTH=8/AMT_W=4 and one at WIDTH=128/AMT_W=8.
// Expected results come from a bit-serial reference model and are queued when each request is issued.
module tb_shift_engine_seq;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;

    shift_engine_seq_if #(.WIDTH(8),   .AMT_W(4)) if8 ();
    shift_engine_seq_if #(.WIDTH(128), .AMT_W(8)) if128 ();

    shift_engine_seq #(.WIDTH(8), .AMT_W(4)) dut8 (
        .clock (clock),
        .reset (reset),
        .bus   (if8.slave)
    );

    shift_engine_seq #(.WIDTH(128), .AMT_W(8)) dut128 (
        .clock (clock),
        .reset (reset),
        .bus   (if128.slave)
    );

    typedef struct {
        logic [127:0] dout;
        logic         carry;
        int           lat;
    } exp_t;

    exp_t sb_q[$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // Reference: apply the operation one bit at a time on the low w bits.
    function automatic void model(input logic [127:0] d, input int w, input logic [2:0] m,
                                  input int amt, input logic [127:0] ser,
                                  output logic [127:0] r, output logic c, output int n);
        logic msb;
        logic lsb;
        logic [127:0] mask;
        mask = (w == 128) ? {128{1'b1}} : ((128'd1 << w) - 128'd1);
        if (m == 3'd7)                    n = 0;
        else if (m == 3'd3 || m == 3'd4)  n = amt;
        else                              n = (amt > w) ? w : amt;
        r = d & mask;
        c = 1'b0;
        for (int k = 0; k < n; k++) begin
            msb = r[w-1];
            lsb = r[0];
            case (m)
                3'd0: begin c = msb; r = (r << 1) & mask; end
                3'd1: begin c = lsb; r = r >> 1; end
                3'd2: begin c = lsb; r = r >> 1; r[w-1] = msb; end
                3'd3: begin c = msb; r = ((r << 1) & mask) | {127'd0, msb}; end
                3'd4: begin c = lsb; r = r >> 1; r[w-1] = lsb; end
                3'd5: begin c = msb; r = ((r << 1) & mask) | {127'd0, ser[k]}; end
                3'd6: begin c = lsb; r = r >> 1; r[w-1] = ser[k]; end
                default: ;
            endcase
        end
    endfunction

    task automatic set_start(input bit wide, input logic v);
        if (wide) if128.start = v;
        else      if8.start   = v;
    endtask

    task automatic run_op(input string tag, input bit wide, input logic [2:0] m, input int amt,
                          input logic [127:0] d, input logic [127:0] ser, input bit mid_start);
        logic [127:0] r;
        logic         c;
        int           n;
        int           done_cnt;
        int           first;
        exp_t         e;
        logic [127:0] obs_dout;
        logic         obs_done;
        logic [127:0] exp_dout;

        model(d, wide ? 128 : 8, m, amt, ser, r, c, n);
        sb_q.push_back('{dout: r, carry: c, lat: n});
        exp_dout = r;

        @(negedge clock);
        if (wide) begin
            if128.mode = m; if128.amount = 8'(amt); if128.din = d;
        end else begin
            if8.mode = m; if8.amount = 4'(amt); if8.din = d[7:0];
        end
        set_start(wide, 1'b1);
        @(posedge clock);
        @(negedge clock);
        set_start(wide, 1'b0);
        if (wide) if128.din = ~d;
        else      if8.din   = ~d[7:0];

        done_cnt = 0;
        first    = -1;
        for (int cyc = 0; cyc <= n + 3; cyc++) begin
            obs_done = wide ? if128.done : if8.done;
            obs_dout = wide ? if128.dout : {120'd0, if8.dout};
            if (obs_done) begin
                done_cnt++;
                if (first < 0) begin
                    first = cyc;
                    if (sb_q.size() == 0) begin
                        chk({tag, "_sb_empty"}, 128'd0, 128'd1);
                    end else begin
                        e = sb_q.pop_front();
                        chk({tag, "_dout"}, obs_dout, e.dout);
                        chk({tag, "_carry"}, 128'(wide ? if128.carry_out : if8.carry_out), 128'(e.carry));
                        chk({tag, "_lat"}, 128'(cyc), 128'(e.lat));
                    end
                end
            end
            if8.serial_in   = (cyc < 128) ? ser[cyc] : 1'b0;
            if128.serial_in = (cyc < 128) ? ser[cyc] : 1'b0;
            if (mid_start) set_start(wide, (cyc >= 1 && cyc <= n) ? 1'b1 : 1'b0);
            @(negedge clock);
        end
        set_start(wide, 1'b0);

        chk({tag, "_done_once"}, 128'(done_cnt), 128'd1);
        if (first < 0 && sb_q.size() > 0) void'(sb_q.pop_front());
        chk({tag, "_idle"}, 128'(wide ? if128.busy : if8.busy), 128'd0);
        obs_dout = wide ? if128.dout : {120'd0, if8.dout};
        chk({tag, "_hold"}, obs_dout, exp_dout);
        $display("op %s mode=%0d amt=%0d dout=%0h done_at=%0d", tag, m, amt, obs_dout, first);
    endtask

    initial begin
        logic [127:0] rnd;
        if8.start = 1'b0;   if8.mode = '0;   if8.amount = '0;   if8.din = '0;   if8.serial_in = 1'b0;
        if128.start = 1'b0; if128.mode = '0; if128.amount = '0; if128.din = '0; if128.serial_in = 1'b0;

        // Start is held high during reset so the bench can confirm that reset wins.
        if8.start = 1'b1; if8.din = 8'hFF; if8.amount = 4'd3;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_busy",  128'(if8.busy), 128'd0);
        chk("rst_done",  128'(if8.done), 128'd0);
        chk("rst_dout",  {120'd0, if8.dout}, 128'd0);
        chk("rst_carry", 128'(if8.carry_out), 128'd0);
        chk("rst_dout128", if128.dout, 128'd0);
        if8.start = 1'b0;
        reset = 1'b0;
        @(negedge clock);

        run_op("asr3",    1'b0, 3'd2, 3,  128'h96, 128'h0, 1'b0);
        run_op("lsl12",   1'b0, 3'd0, 12, 128'hFF, 128'h0, 1'b0);
        run_op("ror9",    1'b0, 3'd4, 9,  128'h81, 128'h0, 1'b0);
        run_op("rol0",    1'b0, 3'd3, 0,  128'h81, 128'h0, 1'b0);
        run_op("shr_ser", 1'b0, 3'd6, 3,  128'h00, 128'h5, 1'b1);
        run_op("hold",    1'b0, 3'd7, 5,  128'h3C, 128'h0, 1'b0);
        run_op("shl_ser", 1'b0, 3'd5, 8,  128'h0F, 128'hB2, 1'b0);
        run_op("rol15",   1'b0, 3'd3, 15, 128'h93, 128'h0, 1'b0);
        run_op("asr8",    1'b0, 3'd2, 8,  128'h80, 128'h0, 1'b0);

        // Reset in the middle of a shift aborts the operation.
        @(negedge clock);
        if8.mode = 3'd0; if8.amount = 4'd5; if8.din = 8'hA5; if8.start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        if8.start = 1'b0;
        @(negedge clock);
        chk("mid_busy", 128'(if8.busy), 128'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("mid_rst_busy",  128'(if8.busy), 128'd0);
        chk("mid_rst_done",  128'(if8.done), 128'd0);
        chk("mid_rst_dout",  {120'd0, if8.dout}, 128'd0);
        chk("mid_rst_carry", 128'(if8.carry_out), 128'd0);
        run_op("post_rst", 1'b0, 3'd1, 7, 128'h80, 128'h0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_op($sformatf("rnd%0d", i), 1'b0, 3'($urandom_range(0, 7)),
                   int'($urandom_range(0, 15)), {120'd0, rnd[7:0]}, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
        end

        run_op("w128_asr127", 1'b1, 3'd2, 127, {1'b1, 127'd0}, 128'h0, 1'b0);
        run_op("w128_lsl200", 1'b1, 3'd0, 200, {$urandom, $urandom, $urandom, $urandom}, 128'h0, 1'b0);
        run_op("w128_rol130", 1'b1, 3'd3, 130, {$urandom, $urandom, $urandom, $urandom}, 128'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
